ahbext_sub: RTL and testbench
=============================

# ahbext_sub

AHB-Lite subordinate that answers the core's external bus port, the HSELEXT region. It gives the external port real responses with configurable wait states and error signalling, replacing tied-off HREADYEXT/HRESPEXT/HRDATAEXT in lint and simulation wrappers. Storage is a small word-addressed flop array. The block sits between the core's AHB manager outputs and the external-response inputs HREADYEXT/HRESPEXT/HRDATAEXT.

## Interface
Parameters:
- AHBW, 64: bus data width in bits. Must equal XLEN.
- PA_BITS, 56: physical address width.
- DEPTH, 256: number of AHBW-wide words. Must be a power of 2.
- BASE, 'h8000_0000: byte base address of the region. Aligned to DEPTH*AHBW/8.
- WAITS, 0: wait cycles inserted per OKAY data phase. Range 0..15.

Ports:
- clk  in  1: single clock; all flops rise on it.
- reset  in  1: asynchronous, active-high reset.
- HSEL  in  1: subordinate select, driven from HSELEXT.
- HREADY  in  1: bus-level ready. An address phase is sampled only when this is 1.
- HADDR  in  PA_BITS: transfer address.
- HTRANS  in  2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1: 1 = write.
- HSIZE, HBURST  in  3 each: ignored. Strobes define the byte lanes.
- HWSTRB  in  AHBW/8: byte write strobes, valid in the data phase.
- HWDATA  in  AHBW: write data, valid in the data phase.
- HRDATA  out  AHBW: read data, meaningful in the final read data-phase cycle.
- HREADYOUT  out  1: data-phase complete. Connects to HREADYEXT.
- HRESP  out  1: 0 = OKAY, 1 = ERROR. Connects to HRESPEXT.

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1].
  - The block registers HADDR-derived index, HWRITE and an in-range flag.
  - BUSY, IDLE or HSEL=0 with HREADY=1 gives an OKAY zero-wait response, with no side effect.
- In range means BASE <= HADDR < BASE + DEPTH*AHBW/8.
  - Word index = (HADDR - BASE) >> log2(AHBW/8), truncated to log2(DEPTH) bits.
  - Low address bits are ignored.
- State machine (data phase):
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accept in range: go to WAIT if WAITS>0, else XFER.
    - Accept out of range: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. A 4-bit counter loads WAITS-1 on entry and decrements. Go to XFER when it reaches 0.
  - XFER: HREADYOUT=1, HRESP=0.
    - Write: commit HWDATA byte lanes where HWSTRB=1 at the clock edge.
    - Read: HRDATA = mem[index].
    - Next state is chosen from a new accept in this cycle, same rules as IDLE. With no accept, go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the same rules as IDLE, so an accept in ERR2 is honoured.
- An out-of-range write never modifies memory.
- HRDATA = 0 in every state except a read XFER.
- Memory contents are not reset. Only control state is reset.
- HMASTLOCK and HPROT are not ports. Bursts are handled beat by beat.

## Timing
- Reset values: state=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0. Applied asynchronously while reset=1.
- OKAY latency, address accept to completing data-phase cycle: 1+WAITS cycles.
- ERROR takes exactly two data-phase cycles, per AHB-Lite.
- Back-to-back: a new address phase overlaps XFER/ERR2 of the previous one. Sustained throughput at WAITS=0 is one transfer per cycle.
- Write followed immediately by a read of the same word: the write commits at the end of its XFER. The read's XFER is the next cycle or later, so the read returns the new data. No forwarding is needed.
- No accept can occur in WAIT or ERR1, because HREADY is 0 there.
- Reset during WAIT or XFER: the pending write is dropped and the block returns to IDLE.
- Counter arithmetic is 4-bit and never wraps, because WAITS<=15.

## Test plan
- Reset: hold reset 3 cycles, with HSEL=1 and HTRANS=NONSEQ asserted during reset -> HREADYOUT=1, HRESP=0, HRDATA=0; no state change after release until an accept.
- WAITS=0, pipelined write then read:
  - Stimulus: write 64'h1122334455667788 to BASE with HWSTRB=8'hFF, then read BASE in the following cycle.
  - Required: HREADYOUT=1 in both data phases, and the read data phase shows HRDATA=64'h1122334455667788.
- Byte strobes:
  - Stimulus: after the previous test, write 64'hAAAAAAAAAAAAAAAA to BASE with HWSTRB=8'h01, then read BASE.
  - Required: HRDATA=64'h11223344556677AA.
- WAITS=2, read of BASE+8:
  - Required: HREADYOUT=0 for exactly 2 cycles, then 1 with data.
  - Required: a second NONSEQ held during the wait is accepted only in the XFER cycle.
- Out of range:
  - Stimulus: write to BASE+DEPTH*8.
  - Required: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
  - Required: a subsequent read of word DEPTH-1 returns its prior value; a valid NONSEQ presented in ERR2 completes OKAY.
- Reset mid-wait:
  - Stimulus: WAITS=3, write 64'hDEAD to BASE+16, assert reset in the second WAIT cycle.
  - Required: HREADYOUT=1 immediately; a later read of BASE+16 returns the pre-write value.

Source files
------------

// File: rtl/ahbext_sub.sv
// AHB-Lite subordinate for the external (HSELEXT) port: a word-addressed flop
// array with programmable wait states and a two-cycle ERROR for out-of-range.
module ahbext_sub #(
  parameter int                 AHBW    = 64,
  parameter int                 PA_BITS = 56,
  parameter int                 DEPTH   = 256,
  parameter logic [PA_BITS-1:0] BASE    = 'h8000_0000,
  parameter int                 WAITS   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic                 HREADY,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [AHBW/8-1:0]    HWSTRB,
  input  logic [AHBW-1:0]      HWDATA,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int                 NBYTES    = AHBW / 8;
  localparam int                 LSB       = $clog2(NBYTES);
  localparam int                 IDX_W     = $clog2(DEPTH);
  localparam logic [PA_BITS-1:0] REGION    = PA_BITS'(DEPTH * NBYTES);
  localparam logic [3:0]         WAIT_LOAD = (WAITS > 0) ? 4'(WAITS - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               write_reg, write_next;

  logic [PA_BITS-1:0] offset;
  logic               in_range;
  logic               can_accept;
  logic               accept;
  logic               mem_we;
  logic [AHBW-1:0]    rd_word;
  logic               unused_bits;

  assign offset     = HADDR - BASE;
  assign in_range   = (HADDR >= BASE) && (offset < REGION);
  // Only the phases that present HREADYOUT=1 may take a new address phase.
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_XFER) ||
                      (state_reg == ST_ERR2);
  assign accept     = HSEL && HREADY && HTRANS[1] && can_accept;
  assign unused_bits = ^{HSIZE, HBURST, HTRANS[0], offset};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    write_next = write_reg;
    case (state_reg)
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_XFER;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
    if (accept) begin
      idx_next   = offset[LSB +: IDX_W];
      write_next = HWRITE;
      if (!in_range) begin
        state_next = ST_ERR1;
      end else if (WAITS > 0) begin
        state_next = ST_WAIT;
        cnt_next   = WAIT_LOAD;
      end else begin
        state_next = ST_XFER;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      write_reg <= write_next;
    end
  end

  // Write commits at the end of the XFER cycle, so a following read sees it.
  assign mem_we = (state_reg == ST_XFER) && write_reg && !reset;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (mem_we && HWSTRB[gi]) lane_mem[idx_reg] <= HWDATA[gi*8 +: 8];
    end

    assign rd_word[gi*8 +: 8] = lane_mem[idx_reg];
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_reg)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_XFER: if (!write_reg) HRDATA = rd_word;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahbext_sub.sv
// Scoreboard bench for ahbext_sub: three instances (WAITS = 0, 2, 3) on a
// shared address/data bus, each selected by its own HSEL.
module tb_ahbext_sub;

  localparam int              NI     = 3;
  localparam int              DEPTH  = 256;
  localparam logic [55:0]     BASE   = 56'h8000_0000;
  localparam logic [55:0]     REGION = 56'd2048;

  typedef struct {
    string       tag;
    int          waits;
    logic        resp;
    logic [63:0] rdata;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NI-1:0] sel;
  logic [55:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [7:0]    hwstrb;
  logic [63:0]   hwdata;
  logic [NI-1:0] hreadyout_v;
  logic [NI-1:0] hresp_v;
  logic [63:0]   hrdata_v [NI];

  exp_t          sb[$];
  logic [63:0]   ref_mem [int];
  int            checks = 0;
  int            errors = 0;
  int            cur = 0;
  bit            pend = 0;
  int            wcnt = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int WTS = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
    ahbext_sub #(
      .AHBW(64), .PA_BITS(56), .DEPTH(DEPTH), .BASE(BASE), .WAITS(WTS)
    ) u_dut (
      .clk(clk), .reset(reset), .HSEL(sel[gi]), .HREADY(hreadyout_v[gi]),
      .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
      .HBURST(hburst), .HWSTRB(hwstrb), .HWDATA(hwdata),
      .HRDATA(hrdata_v[gi]), .HREADYOUT(hreadyout_v[gi]), .HRESP(hresp_v[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one address phase, hold it until accepted, then move to its data phase.
  task automatic drive(input int inst, input bit wr, input logic [55:0] addr,
                       input logic [63:0] data, input logic [7:0] strb,
                       input bit upd, input string tag);
    exp_t        e;
    bit          inr;
    bit          ok;
    int          n;
    int          key;
    logic [63:0] word;
    inr     = (addr >= BASE) && (addr < BASE + REGION);
    key     = inst * DEPTH + int'(((addr - BASE) >> 3) & 56'hFF);
    e.tag   = tag;
    e.waits = inr ? waits_of(inst) : 1;
    e.resp  = !inr;
    e.rdata = 64'd0;
    if (inr && !wr) e.rdata = ref_mem.exists(key) ? ref_mem[key] : 64'd0;
    if (inr && wr && upd) begin
      word = ref_mem.exists(key) ? ref_mem[key] : 64'd0;
      for (int b = 0; b < 8; b++) if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
      ref_mem[key] = word;
    end
    sb.push_back(e);
    cur         = inst;
    sel         = '0;
    sel[inst]   = 1'b1;
    htrans      = 2'b10;
    haddr       = addr;
    hwrite      = wr;
    ok          = 1'b0;
    n           = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = hreadyout_v[inst];
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_accept"}, 64'(ok), 64'd1);
    hwdata = data;
    hwstrb = wr ? strb : 8'h00;
    htrans = 2'b00;
    sel    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        pend = 0;
        wcnt = 0;
      end else begin
        if (pend) begin
          if (!hreadyout_v[cur]) begin
            if (sb.size() > 0) begin
              check({sb[0].tag, "_wait_resp"}, 64'(hresp_v[cur]), 64'(sb[0].resp));
              check({sb[0].tag, "_wait_data"}, hrdata_v[cur], 64'd0);
            end
            wcnt++;
            if (wcnt > 40) begin
              check("stall_waits", 64'(wcnt), 64'd15);
              if (sb.size() > 0) e = sb.pop_front();
              pend = 0;
              wcnt = 0;
            end
          end else begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              $display("txn %s resp=%0d rdata=%h waits=%0d", e.tag, hresp_v[cur],
                       hrdata_v[cur], wcnt);
              check({e.tag, "_resp"}, 64'(hresp_v[cur]), 64'(e.resp));
              check({e.tag, "_rdata"}, hrdata_v[cur], e.rdata);
              check({e.tag, "_waits"}, 64'(wcnt), 64'(e.waits));
            end
            pend = 0;
            wcnt = 0;
          end
        end else begin
          check("idle_ready", 64'(hreadyout_v[cur]), 64'd1);
          check("idle_resp", 64'(hresp_v[cur]), 64'd0);
          check("idle_rdata", hrdata_v[cur], 64'd0);
        end
        if (sel[cur] && hreadyout_v[cur] && htrans[1]) begin
          pend = 1;
          wcnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] d;
    logic [7:0]  s;
    logic [55:0] a;
    reset  = 1'b1;
    sel    = '1;
    htrans = 2'b10;
    haddr  = BASE;
    hwrite = 1'b1;
    hsize  = 3'b011;
    hburst = 3'b000;
    hwstrb = 8'hFF;
    hwdata = '1;

    // Reset held with a live NONSEQ on every instance.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("rst_ready", 64'(hreadyout_v[i]), 64'd1);
        check("rst_resp", 64'(hresp_v[i]), 64'd0);
        check("rst_rdata", hrdata_v[i], 64'd0);
      end
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    htrans = 2'b01;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("busy_ready", 64'(hreadyout_v[i]), 64'd1);
        check("busy_resp", 64'(hresp_v[i]), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    htrans = 2'b00;
    sel    = '0;
    idle(2);

    // WAITS=0: pipelined write/read, byte strobes.
    drive(0, 1, BASE, 64'h1122334455667788, 8'hFF, 1, "wr_base");
    drive(0, 0, BASE, 64'd0, 8'h00, 1, "rd_base");
    drive(0, 1, BASE, 64'hAAAAAAAAAAAAAAAA, 8'h01, 1, "wr_strb01");
    drive(0, 0, BASE, 64'd0, 8'h00, 1, "rd_strb01");
    drive(0, 1, BASE, 64'hCCCCCCCCCCCCCCCC, 8'hF0, 1, "wr_strbF0");
    drive(0, 0, BASE, 64'd0, 8'h00, 1, "rd_strbF0");
    for (int k = 0; k < 5; k++) begin
      a = BASE + 56'(($urandom_range(1, 254)) * 8) + 56'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      drive(0, 1, a, d, 8'hFF, 1, "wr_rand");
      d = {$urandom, $urandom};
      s = 8'($urandom);
      drive(0, 1, a, d, s, 1, "wr_rand_strb");
      drive(0, 0, a, 64'd0, 8'h00, 1, "rd_rand");
    end
    idle(2);

    // Out of range: above top, read in ERR2, then below base.
    drive(0, 1, BASE + 56'd2040, 64'h5555AAAA5555AAAA, 8'hFF, 1, "wr_last");
    drive(0, 1, BASE + REGION, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, "oor_wr_hi");
    drive(0, 0, BASE + 56'd2040, 64'd0, 8'h00, 1, "rd_last_in_err2");
    drive(0, 0, BASE, 64'd0, 8'h00, 1, "rd_word0");
    drive(0, 0, BASE - 56'd8, 64'd0, 8'h00, 1, "oor_rd_lo");
    drive(0, 0, BASE + 56'd2047, 64'd0, 8'h00, 1, "rd_top_byte");
    idle(3);

    // WAITS=2: the second address phase is held across the wait cycles.
    drive(1, 1, BASE + 56'd8, 64'hCAFEF00D12345678, 8'hFF, 1, "w2_wr8");
    drive(1, 1, BASE + 56'd16, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 1, "w2_wr16");
    drive(1, 0, BASE + 56'd8, 64'd0, 8'h00, 1, "w2_rd8");
    drive(1, 0, BASE + 56'd16, 64'd0, 8'h00, 1, "w2_rd16");
    idle(4);

    // WAITS=3: reset lands in the second WAIT cycle of a write.
    drive(2, 1, BASE + 56'd16, 64'h0123456789ABCDEF, 8'hFF, 1, "w3_wr16");
    idle(5);
    drive(2, 1, BASE + 56'd16, 64'h000000000000DEAD, 8'hFF, 0, "w3_abort");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_ready", 64'(hreadyout_v[2]), 64'd1);
    check("arst_resp", 64'(hresp_v[2]), 64'd0);
    check("arst_rdata", hrdata_v[2], 64'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    drive(2, 0, BASE + 56'd16, 64'd0, 8'h00, 1, "w3_rd16_after_rst");
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
